serial_rx_bitsync: RTL and testbench

//  Bit-synchronous serial frame receiver: the read end of the single-bit serial line driven into the dff stage.

---
 rtl/serial_rx_bitsync_if.sv | 16 +
 rtl/serial_rx_bitsync.sv | 122 ++++++++++++
 tb/tb_serial_rx_bitsync.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/serial_rx_bitsync_if.sv
// Parallel-side bundle of the bit-synchronous serial receiver: the serial line in,
// the deframed word and its status strobes out.
interface serial_rx_bitsync_if #(
  parameter int WIDTH = 8
);
  logic             din;
  logic [WIDTH-1:0] dout;
  logic             valid;
  logic             frame_err;
  logic             par_err;
  logic             busy;

  // master: line driver / word consumer; slave: the receiver itself
  modport master (output din, input dout, valid, frame_err, par_err, busy);
  modport slave  (input din, output dout, valid, frame_err, par_err, busy);
endinterface

// File: rtl/serial_rx_bitsync.sv
// Bit-synchronous serial frame receiver: one bit per clk, start/data(LSB first)/[even parity]/stop,
// presents each good word with a one-cycle valid strobe.
module serial_rx_bitsync #(
  parameter int WIDTH     = 8,
  parameter bit PARITY_EN = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  serial_rx_bitsync_if.slave bus
);

  localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t           state, state_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic [WIDTH-1:0] shreg, shreg_d;
  logic             pbad, pbad_d;
  logic [WIDTH-1:0] dout, dout_d;
  logic             valid, valid_d;
  logic             frame_err, frame_err_d;
  logic             par_err, par_err_d;

  // NOTE: every state element, including the shift register, is cleared by reset so an
  // aborted frame can never leak partial data; sequential state uses non-blocking only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      shreg     <= '0;
      pbad      <= 1'b0;
      dout      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      par_err   <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      shreg     <= shreg_d;
      pbad      <= pbad_d;
      dout      <= dout_d;
      valid     <= valid_d;
      frame_err <= frame_err_d;
      par_err   <= par_err_d;
    end
  end

  // NOTE: each variable gets a default before the case so no path leaves it unassigned
  // (no latches); the strobes default low so they last exactly one cycle.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    shreg_d     = shreg;
    pbad_d      = pbad;
    dout_d      = dout;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;
    par_err_d   = 1'b0;

    unique case (state)
      IDLE: begin
        if (!bus.din) begin
          state_d = DATA;
          cnt_d   = '0;
          pbad_d  = 1'b0;
        end
      end

      DATA: begin
        shreg_d[cnt] = bus.din;
        if (cnt == LAST) begin
          state_d = PARITY_EN ? PARITY : STOP;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end

      PARITY: begin
        // even parity: data plus parity bit must contain an even number of ones
        pbad_d  = ^{shreg, bus.din};
        state_d = STOP;
      end

      STOP: begin
        if (bus.din) begin
          if (PARITY_EN && pbad) begin
            par_err_d = 1'b1;
          end else begin
            dout_d  = shreg;
            valid_d = 1'b1;
          end
          state_d = IDLE;
        end else begin
          // a broken stop bit outranks parity and the line must return high before rearming
          frame_err_d = 1'b1;
          state_d     = WAIT_IDLE;
        end
      end

      WAIT_IDLE: begin
        if (bus.din) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.dout      = dout;
  assign bus.valid     = valid;
  assign bus.frame_err = frame_err;
  assign bus.par_err   = par_err;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_serial_rx_bitsync.sv
// Self-checking bench for serial_rx_bitsync: one instance without parity, one with even parity;
// expected strobes are queued when frames are driven and matched as the receivers report them.
module tb_serial_rx_bitsync;

  localparam int W = 8;

  typedef enum int {EV_VALID = 1, EV_FERR = 2, EV_PERR = 3} ev_t;

  typedef struct {
    int         kind;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;

  serial_rx_bitsync_if #(.WIDTH(W)) if0 ();
  serial_rx_bitsync_if #(.WIDTH(W)) if1 ();

  serial_rx_bitsync #(.WIDTH(W), .PARITY_EN(1'b0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
  serial_rx_bitsync #(.WIDTH(W), .PARITY_EN(1'b1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t       q0[$];
  exp_t       q1[$];
  int         vcyc0[$];
  logic [7:0] last_good0 = 8'h00;
  logic [7:0] last_good1 = 8'h00;
  int         n_checks = 0;
  int         n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Match one cycle of receiver status against the head of that channel's scoreboard.
  task automatic observe(input int ch, input logic v, input logic fe, input logic pe,
                         input logic [7:0] d);
    exp_t e;
    int   kind;
    if (!(v || fe || pe)) return;
    kind = v ? EV_VALID : (fe ? EV_FERR : EV_PERR);
    check($sformatf("ch%0d_one_strobe", ch), {29'd0, v, fe, pe} & ({29'd0, v, fe, pe} - 32'd1), 0);
    if (ch == 0 && v) vcyc0.push_back(cyc);
    if ((ch == 0 ? q0.size() : q1.size()) == 0) begin
      check($sformatf("ch%0d_unexpected_strobe", ch), kind, 0);
      return;
    end
    e = (ch == 0) ? q0.pop_front() : q1.pop_front();
    check($sformatf("ch%0d_kind", ch), kind, e.kind);
    check($sformatf("ch%0d_dout", ch), {24'd0, d}, {24'd0, e.data});
    check($sformatf("ch%0d_latency", ch), cyc, e.cyc);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      observe(0, if0.valid, if0.frame_err, if0.par_err, if0.dout);
      observe(1, if1.valid, if1.frame_err, if1.par_err, if1.dout);
    end
  end

  task automatic drive_bit(input int ch, input logic b);
    @(negedge clk);
    if (ch == 0) if0.din = b;
    else         if1.din = b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if0.din = 1'b1;
      if1.din = 1'b1;
    end
  endtask

  // par < 0 sends no parity bit; otherwise par[0] is the parity bit as sent on the line.
  task automatic send(input int ch, input logic [7:0] data, input int par, input logic stop);
    exp_t e;
    logic pbit;
    drive_bit(ch, 1'b0);
    for (int i = 0; i < W; i++) drive_bit(ch, data[i]);
    pbit = par[0];
    if (par >= 0) drive_bit(ch, pbit);
    @(negedge clk);
    e.cyc = cyc + 1;
    if (!stop) begin
      e.kind = EV_FERR;
      e.data = (ch == 0) ? last_good0 : last_good1;
    end else if (par >= 0 && ((^data) ^ pbit)) begin
      e.kind = EV_PERR;
      e.data = (ch == 0) ? last_good0 : last_good1;
    end else begin
      e.kind = EV_VALID;
      e.data = data;
      if (ch == 0) last_good0 = data;
      else         last_good1 = data;
    end
    if (ch == 0) begin q0.push_back(e); if0.din = stop; end
    else         begin q1.push_back(e); if1.din = stop; end
  endtask

  initial begin
    int n;
    if0.din = 1'b1;
    if1.din = 1'b1;

    // reset held while the lines toggle
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if0.din = i[0];
      if1.din = ~i[0];
    end
    @(negedge clk);
    check("rst_dout0", {24'd0, if0.dout}, 0);
    check("rst_strobes0", {29'd0, if0.valid, if0.frame_err, if0.par_err}, 0);
    check("rst_busy0", {31'd0, if0.busy}, 0);
    check("rst_dout1", {24'd0, if1.dout}, 0);
    check("rst_strobes1", {29'd0, if1.valid, if1.frame_err, if1.par_err}, 0);
    check("rst_busy1", {31'd0, if1.busy}, 0);
    if0.din = 1'b1;
    if1.din = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    idle(4);
    check("idle_busy0", {31'd0, if0.busy}, 0);
    check("idle_busy1", {31'd0, if1.busy}, 0);

    // single frame
    send(0, 8'hA5, -1, 1'b1);
    idle(2);
    check("a5_dout_held", {24'd0, if0.dout}, 32'hA5);

    // back-to-back frames, no idle gap
    n = vcyc0.size();
    send(0, 8'h3C, -1, 1'b1);
    send(0, 8'hFF, -1, 1'b1);
    idle(2);
    check("b2b_count", vcyc0.size() - n, 2);
    if (vcyc0.size() >= n + 2) check("b2b_gap", vcyc0[n+1] - vcyc0[n], 10);
    check("b2b_dout", {24'd0, if0.dout}, 32'hFF);

    // broken stop bit, line then held low: must not be taken as a start bit
    send(0, 8'h55, -1, 1'b0);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b0);
    check("ferr_wait_busy", {31'd0, if0.busy}, 1);
    drive_bit(0, 1'b1);
    idle(3);
    check("ferr_no_false_start", {31'd0, if0.busy}, 0);
    check("ferr_dout_kept", {24'd0, if0.dout}, 32'hFF);

    // even parity instance: good then bad parity bit
    send(1, 8'h07, 1, 1'b1);
    send(1, 8'h07, 0, 1'b1);
    idle(2);
    check("par_dout", {24'd0, if1.dout}, 32'h07);
    send(1, 8'hC3, 0, 1'b1);
    idle(2);
    check("par_dout2", {24'd0, if1.dout}, 32'hC3);

    // reset after the 4th data bit of 0x81
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b0);
    @(negedge clk);
    rst     = 1'b0;
    if0.din = 1'b1;
    #1;
    check("abort_busy", {31'd0, if0.busy}, 0);
    check("abort_dout", {24'd0, if0.dout}, 0);
    check("abort_strobes", {29'd0, if0.valid, if0.frame_err, if0.par_err}, 0);
    last_good0 = 8'h00;
    last_good1 = 8'h00;
    @(negedge clk);
    rst = 1'b1;
    idle(10);
    check("abort_idle", {31'd0, if0.busy}, 0);
    send(0, 8'h42, -1, 1'b1);
    idle(2);
    check("post_abort_dout", {24'd0, if0.dout}, 32'h42);

    idle(3);
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
